// File: rtl/forward_history_unit.sv
// Purpose: two-deep history of in-flight results (MEM = oneAway, WB = Btb) feeding the jump/branch operand mux.
// Latency: slots update on the clock edge; the select, hazard and load_stall outputs are combinational from slot state and src_reg.
// Backpressure: stall holds both slots; flush still kills the slot1 capture. A load hit in slot1 raises load_stall until the load moves on.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   stall, flush               pipeline hold / kill of the EX instruction
//   ex_valid/ex_wr_en/ex_wide/ex_is_load/ex_dst/ex_result  EX-stage instruction being captured into slot1
//   mem_rdata                  load data returned in MEM, folded into slot2 as a load advances
//   rd_en, src_reg             decode-stage read of the jump/branch operand
//   oneAway, Btb               slot1 / slot2 result views
//   hazard, ForwardToMux4      forward request and select code for the operand mux
//   load_stall                 load-use stall request to IF/ID
module forward_history_unit #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int HI_REG = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic                  ex_wr_en,
  input  logic                  ex_wide,
  input  logic                  ex_is_load,
  input  logic [REG_AW-1:0]     ex_dst,
  input  logic [2*DATA_W-1:0]   ex_result,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  rd_en,
  input  logic [REG_AW-1:0]     src_reg,
  output logic [2*DATA_W-1:0]   oneAway,
  output logic [2*DATA_W-1:0]   Btb,
  output logic                  hazard,
  output logic [2:0]            ForwardToMux4,
  output logic                  load_stall
);

  localparam logic [REG_AW-1:0] HI_IDX = REG_AW'(HI_REG);

  // slot1 still needs is_load; by the time an entry reaches slot2 its load
  // data has been substituted, so slot2 carries no is_load flag.
  typedef struct packed {
    logic                valid;
    logic                wr_en;
    logic                wide;
    logic                is_load;
    logic [REG_AW-1:0]   dst;
    logic [2*DATA_W-1:0] data;
  } slot1_t;

  typedef struct packed {
    logic                valid;
    logic                wr_en;
    logic                wide;
    logic [REG_AW-1:0]   dst;
    logic [2*DATA_W-1:0] data;
  } slot2_t;

  slot1_t s1;
  slot2_t s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else if (stall) begin
      // flush wins over stall for slot1 only: the EX kill must not be lost
      // while the pipe is held.
      if (flush) begin
        s1.valid <= 1'b0;
      end
    end else begin
      s2.valid <= s1.valid;
      s2.wr_en <= s1.wr_en;
      s2.wide  <= s1.wide;
      s2.dst   <= s1.dst;
      s2.data  <= s1.is_load ? {{DATA_W{1'b0}}, mem_rdata} : s1.data;
      if (ex_valid && !flush) begin
        s1.valid   <= 1'b1;
        s1.wr_en   <= ex_wr_en;
        s1.wide    <= ex_wide;
        s1.is_load <= ex_is_load;
        s1.dst     <= ex_dst;
        s1.data    <= ex_result;
      end else begin
        s1 <= '0;
      end
    end
  end

  assign oneAway = s1.data;
  assign Btb     = s2.data;

  logic lo1, hi1, lo2, hi2;

  assign lo1 = s1.valid & s1.wr_en & (s1.dst == src_reg);
  assign hi1 = s1.valid & s1.wide  & (src_reg == HI_IDX);
  assign lo2 = s2.valid & s2.wr_en & (s2.dst == src_reg);
  assign hi2 = s2.valid & s2.wide  & (src_reg == HI_IDX);

  // Newer slot beats older; within a slot the upper half beats the lower,
  // so a wide op targeting HI_REG resolves to its upper half.
  always_comb begin
    ForwardToMux4 = 3'b000;
    load_stall    = 1'b0;
    if (rd_en) begin
      if ((lo1 | hi1) & s1.is_load) begin
        load_stall = 1'b1;
      end else if (hi1) begin
        ForwardToMux4 = 3'b100;
      end else if (lo1) begin
        ForwardToMux4 = 3'b011;
      end else if (hi2) begin
        ForwardToMux4 = 3'b010;
      end else if (lo2) begin
        ForwardToMux4 = 3'b001;
      end
    end
  end

  assign hazard = |ForwardToMux4;

endmodule

// File: tb/tb_forward_history_unit.sv
// Purpose: directed-vector bench for forward_history_unit with an in-bench history model.
// Latency: model history advances on the same edges as the DUT; outputs are compared on every falling edge.
// Backpressure: stall/flush and load-use sequences are driven explicitly from the stimulus.
module tb_forward_history_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush;
  logic        ex_valid, ex_wr_en, ex_wide, ex_is_load;
  logic [3:0]  ex_dst;
  logic [31:0] ex_result;
  logic [15:0] mem_rdata;
  logic        rd_en;
  logic [3:0]  src_reg;
  logic [31:0] oneAway, Btb;
  logic        hazard;
  logic [2:0]  ForwardToMux4;
  logic        load_stall;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  forward_history_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_wr_en(ex_wr_en), .ex_wide(ex_wide),
    .ex_is_load(ex_is_load), .ex_dst(ex_dst), .ex_result(ex_result),
    .mem_rdata(mem_rdata), .rd_en(rd_en), .src_reg(src_reg),
    .oneAway(oneAway), .Btb(Btb), .hazard(hazard),
    .ForwardToMux4(ForwardToMux4), .load_stall(load_stall)
  );

  always #5 clk = ~clk;

  // History model: hist[0] is the newest in-flight result, hist[1] the older.
  typedef struct {
    bit          v;
    bit          wr;
    bit          wide;
    bit          ld;
    bit [3:0]    dst;
    bit [31:0]   data;
  } rec_t;

  rec_t hist[2];

  function automatic rec_t empty_rec();
    rec_t r;
    r.v = 0; r.wr = 0; r.wide = 0; r.ld = 0; r.dst = 0; r.data = 0;
    return r;
  endfunction

  task automatic model_clear();
    hist[0] = empty_rec();
    hist[1] = empty_rec();
  endtask

  // Walk the history newest-first; the first entry that supplies src_reg decides.
  task automatic model_sel(output bit [2:0] code, output bit ls);
    code = 3'b000;
    ls   = 1'b0;
    if (rd_en) begin
      for (int age = 0; age < 2; age++) begin
        bit gives_hi, gives_lo;
        gives_hi = hist[age].v && hist[age].wide && (src_reg == 4'd15);
        gives_lo = hist[age].v && hist[age].wr && (hist[age].dst == src_reg);
        if (gives_hi || gives_lo) begin
          if (age == 0 && hist[0].ld) ls = 1'b1;
          else if (gives_hi) code = (age == 0) ? 3'b100 : 3'b010;
          else code = (age == 0) ? 3'b011 : 3'b001;
          break;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      bit [2:0] code;
      bit ls;
      model_sel(code, ls);
      check("model oneAway", oneAway, hist[0].data);
      check("model Btb", Btb, hist[1].data);
      check("model code", {29'd0, ForwardToMux4}, {29'd0, code});
      check("model hazard", {31'd0, hazard}, {31'd0, (code != 3'b000)});
      check("model load_stall", {31'd0, load_stall}, {31'd0, ls});
    end
  end

  // One clock edge: the model's next history is computed from the inputs held
  // across the edge, then committed right at the edge.
  task automatic step();
    rec_t n0, n1;
    if (stall) begin
      n0 = hist[0];
      n1 = hist[1];
      if (flush) n0.v = 0;
    end else begin
      n1 = hist[0];
      if (hist[0].ld) n1.data = {16'h0000, mem_rdata};
      n1.ld = 0;
      if (ex_valid && !flush) begin
        n0.v = 1; n0.wr = ex_wr_en; n0.wide = ex_wide; n0.ld = ex_is_load;
        n0.dst = ex_dst; n0.data = ex_result;
      end else begin
        n0 = empty_rec();
      end
    end
    @(posedge clk);
    hist[0] = n0;
    hist[1] = n1;
    #1;
  endtask

  task automatic ex(input bit v, input bit wr, input bit wide, input bit ld,
                    input bit [3:0] dst, input bit [31:0] res);
    ex_valid = v; ex_wr_en = wr; ex_wide = wide; ex_is_load = ld;
    ex_dst = dst; ex_result = res;
  endtask

  task automatic idle();
    ex(0, 0, 0, 0, 4'd0, 32'h0);
  endtask

  task automatic rd(input bit en, input bit [3:0] r);
    rd_en = en; src_reg = r; #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 0; flush = 0; mem_rdata = 16'h0;
    idle();
    rd_en = 1; src_reg = 4'd0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("reset oneAway", oneAway, 32'h0);
    check("reset Btb", Btb, 32'h0);
    check("reset code", {29'd0, ForwardToMux4}, 32'd0);
    check("reset load_stall", {31'd0, load_stall}, 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Back-to-back writes of R3: the newer one wins.
    ex(1, 1, 0, 0, 4'd3, 32'h0000_1234); step();
    ex(1, 1, 0, 0, 4'd3, 32'h0000_5678); step();
    idle(); rd(1, 4'd3);
    check("b2b code", {29'd0, ForwardToMux4}, 32'd3);
    check("b2b oneAway", {16'd0, oneAway[15:0]}, 32'h5678);
    check("b2b hazard", {31'd0, hazard}, 32'd1);
    step();
    check("b2b bubble code", {29'd0, ForwardToMux4}, 32'd1);
    check("b2b bubble Btb", {16'd0, Btb[15:0]}, 32'h5678);

    // Wide op: dst R2 gets the lower half, R15 the upper half.
    ex(1, 1, 1, 0, 4'd2, 32'hBEEF_0042); step();
    idle(); rd(1, 4'd15);
    check("wide hi1 code", {29'd0, ForwardToMux4}, 32'd4);
    rd(1, 4'd2);
    check("wide lo1 code", {29'd0, ForwardToMux4}, 32'd3);
    step(); rd(1, 4'd15);
    check("wide hi2 code", {29'd0, ForwardToMux4}, 32'd2);
    rd(1, 4'd2);
    check("wide lo2 code", {29'd0, ForwardToMux4}, 32'd1);

    // Wide op into R15 itself: upper half beats lower half.
    ex(1, 1, 1, 0, 4'd15, 32'hCAFE_0001); step();
    idle(); rd(1, 4'd15);
    check("wide self code", {29'd0, ForwardToMux4}, 32'd4);
    // Newer plain write of R15 beats the older wide op.
    ex(1, 1, 0, 0, 4'd15, 32'h0000_7777); step();
    idle(); rd(1, 4'd15);
    check("newer lo beats older hi", {29'd0, ForwardToMux4}, 32'd3);

    // Load-use on R5.
    ex(1, 1, 0, 1, 4'd5, 32'h0000_1000); step();
    idle(); rd(1, 4'd5);
    check("load stall", {31'd0, load_stall}, 32'd1);
    check("load hazard", {31'd0, hazard}, 32'd0);
    check("load code", {29'd0, ForwardToMux4}, 32'd0);
    mem_rdata = 16'h00AA; step();
    check("load fwd code", {29'd0, ForwardToMux4}, 32'd1);
    check("load fwd Btb", Btb, 32'h0000_00AA);
    check("load fwd stall clear", {31'd0, load_stall}, 32'd0);

    // Load-use held under stall.
    ex(1, 1, 0, 1, 4'd6, 32'h0000_2000); step();
    idle(); rd(1, 4'd6);
    stall = 1; step(); step();
    check("load stall held", {31'd0, load_stall}, 32'd1);
    stall = 0; mem_rdata = 16'h00BB; step();
    check("load held fwd code", {29'd0, ForwardToMux4}, 32'd1);
    check("load held fwd Btb", Btb, 32'h0000_00BB);

    // Stall for three cycles, then flush under stall.
    ex(1, 1, 0, 0, 4'd7, 32'h0000_1111); step();
    ex(1, 1, 0, 0, 4'd7, 32'h0000_2222); step();
    idle(); rd(1, 4'd7);
    stall = 1;
    ex(1, 1, 0, 0, 4'd7, 32'h0000_3333);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall code", {29'd0, ForwardToMux4}, 32'd3);
      check("stall oneAway", oneAway, 32'h0000_2222);
    end
    flush = 1; step(); flush = 0;
    check("flush falls back code", {29'd0, ForwardToMux4}, 32'd1);
    check("flush Btb", Btb, 32'h0000_1111);
    rd(1, 4'd9);
    check("flush no match", {29'd0, ForwardToMux4}, 32'd0);
    stall = 0; idle(); step();

    // rd_en low masks everything, including a load hit.
    ex(1, 1, 0, 0, 4'd4, 32'h0000_0044); step();
    idle(); rd(0, 4'd4);
    check("rd_en off hazard", {31'd0, hazard}, 32'd0);
    check("rd_en off code", {29'd0, ForwardToMux4}, 32'd0);
    ex(1, 1, 0, 1, 4'd4, 32'h0000_0000); step();
    idle();
    check("rd_en off load_stall", {31'd0, load_stall}, 32'd0);
    mem_rdata = 16'h0; step();

    // Asynchronous reset mid-cycle with both slots valid.
    ex(1, 1, 0, 0, 4'd1, 32'h0000_00C1); step();
    ex(1, 1, 0, 0, 4'd2, 32'h0000_00C2); step();
    idle(); rd(1, 4'd2);
    #1;
    rst_n = 1'b0;
    model_clear();
    #1;
    check("async rst oneAway", oneAway, 32'h0);
    check("async rst Btb", Btb, 32'h0);
    check("async rst hazard", {31'd0, hazard}, 32'd0);
    check("async rst code", {29'd0, ForwardToMux4}, 32'd0);
    rst_n = 1'b1;
    step(); step();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
